// File: rtl/decode_stage.sv
// RV32I decode stage: one-entry registered output with valid/ready handshake,
// flush, load-use bubble insertion and an optional ASCII mnemonic for debug.
module decode_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned STR_CHARS  = 10,
  parameter bit          ENABLE_STR = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  input  logic [XLEN-1:0]        in_pc,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [XLEN-1:0]        out_imm,
  output logic [4:0]             out_rd,
  output logic [4:0]             out_rs1,
  output logic [4:0]             out_rs2,
  output logic [6:0]             out_opcode,
  output logic [2:0]             out_func3,
  output logic [3:0]             out_alu_ctrl,
  output logic                   out_reg_write,
  output logic                   out_is_load,
  output logic                   out_is_store,
  output logic                   out_is_branch,
  output logic                   out_is_jump,
  output logic                   out_illegal,
  output logic [8*STR_CHARS-1:0] out_decode_str,
  output logic                   stall_load_use
);

  localparam int unsigned StrW = 8 * STR_CHARS;

  localparam logic [3:0] AluAdd = 4'h0, AluSub = 4'h1, AluXor = 4'h2, AluOr = 4'h3,
                         AluAnd = 4'h4, AluSll = 4'h5, AluSrl = 4'h6, AluSra = 4'h7,
                         AluSlt = 4'h8, AluSltu = 4'h9, AluPassB = 4'hA;

  localparam logic [6:0] OpR = 7'b0110011, OpImm = 7'b0010011, OpLoad = 7'b0000011,
                         OpStore = 7'b0100011, OpBranch = 7'b1100011, OpJal = 7'b1101111,
                         OpJalr = 7'b1100111, OpLui = 7'b0110111, OpAuipc = 7'b0010111;

  // Raw instruction fields
  logic [6:0] w_op, w_f7;
  logic [2:0] w_f3;
  assign w_op = in_instr[6:0];
  assign w_f3 = in_instr[14:12];
  assign w_f7 = in_instr[31:25];

  logic [31:0] w_imm32;
  logic [3:0]  w_alu, w_alu_f3;
  logic        w_rd_use, w_rs1_use, w_rs2_use;
  logic        w_load, w_store, w_branch, w_jump, w_illegal;
  logic [63:0] w_mn, w_mn_f3;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic        w_reg_write;

  // ALU op and mnemonic shared by R and I-ALU formats, selected by func3
  always_comb begin
    w_alu_f3 = AluAdd;
    w_mn_f3  = 64'("ADD");
    unique case (w_f3)
      3'd0: begin w_alu_f3 = AluAdd;  w_mn_f3 = 64'("ADD");  end
      3'd1: begin w_alu_f3 = AluSll;  w_mn_f3 = 64'("SLL");  end
      3'd2: begin w_alu_f3 = AluSlt;  w_mn_f3 = 64'("SLT");  end
      3'd3: begin w_alu_f3 = AluSltu; w_mn_f3 = 64'("SLTU"); end
      3'd4: begin w_alu_f3 = AluXor;  w_mn_f3 = 64'("XOR");  end
      3'd5: begin
        w_alu_f3 = in_instr[30] ? AluSra : AluSrl;
        w_mn_f3  = in_instr[30] ? 64'("SRA") : 64'("SRL");
      end
      3'd6: begin w_alu_f3 = AluOr;   w_mn_f3 = 64'("OR");   end
      default: begin w_alu_f3 = AluAnd; w_mn_f3 = 64'("AND"); end
    endcase
  end

  // Full combinational decode of the incoming instruction
  always_comb begin
    w_imm32   = '0;
    w_alu     = AluAdd;
    w_rd_use  = 1'b0;
    w_rs1_use = 1'b0;
    w_rs2_use = 1'b0;
    w_load    = 1'b0;
    w_store   = 1'b0;
    w_branch  = 1'b0;
    w_jump    = 1'b0;
    w_illegal = 1'b0;
    w_mn      = 64'("ILLEGAL");
    unique case (w_op)
      OpR: begin
        {w_rd_use, w_rs1_use, w_rs2_use} = 3'b111;
        w_alu = w_alu_f3;
        w_mn  = w_mn_f3;
        if (w_f7 == 7'h20 && w_f3 == 3'd0) begin
          w_alu = AluSub;
          w_mn  = 64'("SUB");
        end else if (!(w_f7 == 7'h00 || (w_f7 == 7'h20 && w_f3 == 3'd5))) begin
          w_illegal = 1'b1;
        end
      end
      OpImm: begin
        {w_rd_use, w_rs1_use} = 2'b11;
        w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        w_alu   = w_alu_f3;
        // SLTU's immediate form is spelled SLTIU, the rest just gain an I suffix
        w_mn    = (w_f3 == 3'd3) ? 64'("SLTIU") : {w_mn_f3[55:0], 8'h49};
        if (w_f3 == 3'd1 && w_f7 != 7'h00) w_illegal = 1'b1;
        if (w_f3 == 3'd5 && w_f7 != 7'h00 && w_f7 != 7'h20) w_illegal = 1'b1;
      end
      OpLoad: begin
        {w_rd_use, w_rs1_use, w_load} = 3'b111;
        w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        unique case (w_f3)
          3'd0: w_mn = 64'("LB");
          3'd1: w_mn = 64'("LH");
          3'd2: w_mn = 64'("LW");
          3'd4: w_mn = 64'("LBU");
          3'd5: w_mn = 64'("LHU");
          default: w_illegal = 1'b1;
        endcase
      end
      OpStore: begin
        {w_rs1_use, w_rs2_use, w_store} = 3'b111;
        w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        unique case (w_f3)
          3'd0: w_mn = 64'("SB");
          3'd1: w_mn = 64'("SH");
          3'd2: w_mn = 64'("SW");
          default: w_illegal = 1'b1;
        endcase
      end
      OpBranch: begin
        {w_rs1_use, w_rs2_use, w_branch} = 3'b111;
        w_alu   = AluSub;
        w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
        unique case (w_f3)
          3'd0: w_mn = 64'("BEQ");
          3'd1: w_mn = 64'("BNE");
          3'd4: w_mn = 64'("BLT");
          3'd5: w_mn = 64'("BGE");
          3'd6: w_mn = 64'("BLTU");
          3'd7: w_mn = 64'("BGEU");
          default: w_illegal = 1'b1;
        endcase
      end
      OpJal: begin
        {w_rd_use, w_jump} = 2'b11;
        w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
        w_mn    = 64'("JAL");
      end
      OpJalr: begin
        {w_rd_use, w_rs1_use, w_jump} = 3'b111;
        w_imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
        w_mn      = 64'("JALR");
        w_illegal = (w_f3 != 3'd0);
      end
      OpLui: begin
        w_rd_use = 1'b1;
        w_alu    = AluPassB;
        w_imm32  = {in_instr[31:12], 12'h000};
        w_mn     = 64'("LUI");
      end
      OpAuipc: begin
        w_rd_use = 1'b1;
        w_imm32  = {in_instr[31:12], 12'h000};
        w_mn     = 64'("AUIPC");
      end
      default: w_illegal = 1'b1;
    endcase
    // Illegal words carry only the trap: no register usage, no class flags
    if (w_illegal) begin
      {w_rd_use, w_rs1_use, w_rs2_use} = 3'b000;
      {w_load, w_store, w_branch, w_jump} = 4'b0000;
      w_alu   = AluAdd;
      w_imm32 = '0;
      w_mn    = 64'("ILLEGAL");
    end
  end

  assign w_rd        = w_rd_use  ? in_instr[11:7]  : 5'd0;
  assign w_rs1       = w_rs1_use ? in_instr[19:15] : 5'd0;
  assign w_rs2       = w_rs2_use ? in_instr[24:20] : 5'd0;
  assign w_reg_write = w_rd_use && (in_instr[11:7] != 5'd0);

  // Output register state
  logic            r_valid, r_reg_write, r_load, r_store, r_branch, r_jump, r_illegal;
  logic [XLEN-1:0] r_pc, r_imm;
  logic [4:0]      r_rd, r_rs1, r_rs2;
  logic [6:0]      r_opcode;
  logic [2:0]      r_func3;
  logic [3:0]      r_alu;
  logic [StrW-1:0] r_str;

  // Unused source registers decode to 0, so they can never match a nonzero rd
  logic w_hazard, w_accept;
  assign w_hazard = r_valid && r_load && (r_rd != 5'd0) && in_valid &&
                    ((w_rs1 == r_rd) || (w_rs2 == r_rd));
  assign in_ready = !reset && !flush && !w_hazard && (!r_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign stall_load_use = w_hazard;

  // Output register: reset, flush, accept, drain/bubble, else hold
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_imm       <= '0;
      r_rd        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_opcode    <= '0;
      r_func3     <= '0;
      r_alu       <= '0;
      r_reg_write <= 1'b0;
      r_load      <= 1'b0;
      r_store     <= 1'b0;
      r_branch    <= 1'b0;
      r_jump      <= 1'b0;
      r_illegal   <= 1'b0;
      r_str       <= StrW'(64'("RESET"));
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid     <= 1'b1;
      r_pc        <= in_pc;
      r_imm       <= XLEN'($signed(w_imm32));
      r_rd        <= w_rd;
      r_rs1       <= w_rs1;
      r_rs2       <= w_rs2;
      r_opcode    <= w_op;
      r_func3     <= w_f3;
      r_alu       <= w_alu;
      r_reg_write <= w_reg_write;
      r_load      <= w_load;
      r_store     <= w_store;
      r_branch    <= w_branch;
      r_jump      <= w_jump;
      r_illegal   <= w_illegal;
      r_str       <= StrW'(w_mn);
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid      = r_valid;
  assign out_pc         = r_pc;
  assign out_imm        = r_imm;
  assign out_rd         = r_rd;
  assign out_rs1        = r_rs1;
  assign out_rs2        = r_rs2;
  assign out_opcode     = r_opcode;
  assign out_func3      = r_func3;
  assign out_alu_ctrl   = r_alu;
  assign out_reg_write  = r_reg_write;
  assign out_is_load    = r_load;
  assign out_is_store   = r_store;
  assign out_is_branch  = r_branch;
  assign out_is_jump    = r_jump;
  assign out_illegal    = r_illegal;
  assign out_decode_str = ENABLE_STR ? r_str : '0;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, out_imm;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [6:0]  out_opcode;
  logic [2:0]  out_func3;
  logic [3:0]  out_alu_ctrl;
  logic        out_reg_write, out_is_load, out_is_store, out_is_branch, out_is_jump;
  logic        out_illegal, stall_load_use;
  logic [79:0] out_decode_str;

  int errors = 0;
  int checks = 0;
  logic [31:0] held_imm;

  decode_stage #(.XLEN(32), .STR_CHARS(10), .ENABLE_STR(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm), .out_rd(out_rd),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_opcode(out_opcode), .out_func3(out_func3),
    .out_alu_ctrl(out_alu_ctrl), .out_reg_write(out_reg_write), .out_is_load(out_is_load),
    .out_is_store(out_is_store), .out_is_branch(out_is_branch), .out_is_jump(out_is_jump),
    .out_illegal(out_illegal), .out_decode_str(out_decode_str),
    .stall_load_use(stall_load_use)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
    tick();
    chk("rst_valid", 80'(out_valid), 80'(0));
    chk("rst_rd", 80'(out_rd), 80'(0));
    chk("rst_imm", 80'(out_imm), 80'(0));
    chk("rst_str", out_decode_str, 80'("RESET"));
    chk("rst_in_ready", 80'(in_ready), 80'(0));
    reset = 1'b0;
    #1;
    chk("idle_in_ready", 80'(in_ready), 80'(1));

    // ADD x3,x1,x2
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h100;
    tick();
    chk("add_valid", 80'(out_valid), 80'(1));
    chk("add_rd", 80'(out_rd), 80'(3));
    chk("add_rs1", 80'(out_rs1), 80'(1));
    chk("add_rs2", 80'(out_rs2), 80'(2));
    chk("add_alu", 80'(out_alu_ctrl), 80'(0));
    chk("add_we", 80'(out_reg_write), 80'(1));
    chk("add_pc", 80'(out_pc), 80'(32'h100));
    chk("add_str", out_decode_str, 80'("ADD"));

    // SUB x5,x6,x7
    in_instr = 32'h407302B3; in_pc = 32'h104;
    tick();
    chk("sub_alu", 80'(out_alu_ctrl), 80'(1));
    chk("sub_rd", 80'(out_rd), 80'(5));
    chk("sub_str", out_decode_str, 80'("SUB"));

    // Shift-right R-type with func7 0x40 is illegal
    in_instr = 32'h807352B3; in_pc = 32'h108;
    tick();
    chk("bad_f7_valid", 80'(out_valid), 80'(1));
    chk("bad_f7_ill", 80'(out_illegal), 80'(1));
    chk("bad_f7_rd", 80'(out_rd), 80'(0));
    chk("bad_f7_we", 80'(out_reg_write), 80'(0));
    chk("bad_f7_str", out_decode_str, 80'("ILLEGAL"));

    // LW x5,8(x1) followed by dependent ADD x6,x5,x0
    in_instr = 32'h0080A283; in_pc = 32'h10C;
    tick();
    chk("lw_load", 80'(out_is_load), 80'(1));
    chk("lw_rd", 80'(out_rd), 80'(5));
    chk("lw_imm", 80'(out_imm), 80'(8));
    chk("lw_str", out_decode_str, 80'("LW"));
    in_instr = 32'h00028333; in_pc = 32'h110;
    #1;
    chk("hz_stall", 80'(stall_load_use), 80'(1));
    chk("hz_in_ready", 80'(in_ready), 80'(0));
    tick();
    chk("hz_bubble", 80'(out_valid), 80'(0));
    chk("hz_stall_clr", 80'(stall_load_use), 80'(0));
    chk("hz_ready_again", 80'(in_ready), 80'(1));
    tick();
    chk("dep_valid", 80'(out_valid), 80'(1));
    chk("dep_rd", 80'(out_rd), 80'(6));
    chk("dep_rs1", 80'(out_rs1), 80'(5));
    chk("dep_str", out_decode_str, 80'("ADD"));

    // JAL x1,-4
    in_instr = 32'hFFDFF0EF; in_pc = 32'h114;
    tick();
    chk("jal_imm", 80'(out_imm), 80'(32'hFFFF_FFFC));
    chk("jal_rd", 80'(out_rd), 80'(1));
    chk("jal_jump", 80'(out_is_jump), 80'(1));
    chk("jal_alu", 80'(out_alu_ctrl), 80'(0));
    chk("jal_str", out_decode_str, 80'("JAL"));

    // All-zero word
    in_instr = 32'h00000000;
    tick();
    chk("zero_ill", 80'(out_illegal), 80'(1));
    chk("zero_str", out_decode_str, 80'("ILLEGAL"));

    // SW x2,12(x1)
    in_instr = 32'h0020A623;
    tick();
    chk("sw_store", 80'(out_is_store), 80'(1));
    chk("sw_rd", 80'(out_rd), 80'(0));
    chk("sw_rs2", 80'(out_rs2), 80'(2));
    chk("sw_imm", 80'(out_imm), 80'(12));
    chk("sw_we", 80'(out_reg_write), 80'(0));

    // BNE x1,x2,-8
    in_instr = 32'hFE209CE3;
    tick();
    chk("bne_imm", 80'(out_imm), 80'(32'hFFFF_FFF8));
    chk("bne_alu", 80'(out_alu_ctrl), 80'(1));
    chk("bne_br", 80'(out_is_branch), 80'(1));
    chk("bne_str", out_decode_str, 80'("BNE"));

    // LUI x7,0x12345 then hold under backpressure
    in_instr = 32'h123453B7;
    tick();
    chk("lui_imm", 80'(out_imm), 80'(32'h1234_5000));
    chk("lui_alu", 80'(out_alu_ctrl), 80'(4'hA));
    chk("lui_str", out_decode_str, 80'("LUI"));
    held_imm = 32'h1234_5000;
    out_ready = 1'b0; in_instr = 32'h002081B3;
    #1;
    chk("bp_in_ready", 80'(in_ready), 80'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", 80'(out_valid), 80'(1));
      chk("bp_imm", 80'(out_imm), 80'(held_imm));
      chk("bp_rd", 80'(out_rd), 80'(7));
      chk("bp_in_ready", 80'(in_ready), 80'(0));
    end
    out_ready = 1'b1; in_valid = 1'b0;
    tick();
    chk("drain_valid", 80'(out_valid), 80'(0));

    // Flush with a held instruction and an incoming one
    in_valid = 1'b1; in_instr = 32'h002081B3;
    tick();
    chk("pre_flush_valid", 80'(out_valid), 80'(1));
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 80'(in_ready), 80'(0));
    tick();
    chk("flush_valid", 80'(out_valid), 80'(0));
    flush = 1'b0;

    // Mid-stream reset while stalled downstream
    in_instr = 32'hFFDFF0EF; in_pc = 32'h200;
    tick();
    chk("pre_rst_valid", 80'(out_valid), 80'(1));
    reset = 1'b1; out_ready = 1'b0;
    tick();
    chk("mrst_valid", 80'(out_valid), 80'(0));
    chk("mrst_rd", 80'(out_rd), 80'(0));
    chk("mrst_imm", 80'(out_imm), 80'(0));
    chk("mrst_pc", 80'(out_pc), 80'(0));
    chk("mrst_jump", 80'(out_is_jump), 80'(0));
    chk("mrst_str", out_decode_str, 80'("RESET"));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised RV32I decode stage sitting between the IF/ID register and execute in the 5-stage pipeline. It accepts one instruction per cycle over a valid/ready handshake and fully decodes every RV32I base format, including correct J-immediates, a complete ALU control map and illegal-instruction detection. It holds the result in a one-entry output register with backpressure, flush and load-use hazard bubble insertion. An optional uppercase ASCII mnemonic feeds the VGA debug display.

## Interface
- XLEN, 32: datapath width of imm/pc; immediates sign-extended to XLEN (U-imm sign-extended from bit 31).
- STR_CHARS, 10: mnemonic length; decode_str is 8*STR_CHARS bits.
- ENABLE_STR, 1: 0 ties out_decode_str to 0.
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid / in_ready  in / out  1  upstream handshake; transfer when both high.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- flush  in  1  kill held and incoming instruction.
- out_valid / out_ready  out / in  1  downstream handshake.
- out_pc, out_imm  out  XLEN  registered pc, decoded immediate.
- out_rd, out_rs1, out_rs2  out  5  register indices; 0 when unused by format.
- out_opcode / out_func3  out  7 / 3  raw fields.
- out_alu_ctrl  out  4  ALU operation.
- out_reg_write, out_is_load, out_is_store, out_is_branch, out_is_jump, out_illegal  out  1 each  class flags.
- out_decode_str  out  8*STR_CHARS  uppercase mnemonic, right-aligned, zero-filled upper bytes.
- stall_load_use  out  1  hazard bubble being inserted this cycle.

## Operation
- ALU map: ADD 0, SUB 1, XOR 2, OR 3, AND 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9, PASSB A (LUI). Loads, stores, JAL, JALR, AUIPC use ADD; branches use SUB; I-ALU ops map by func3; SRAI/SRA selected by instr[30].
- Formats: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111 (J-imm), JALR 1100111 (I-imm), LUI 0110111, AUIPC 0010111 (U-imm).
- rs1 used by R, I-ALU, LOAD, STORE, BRANCH, JALR. rs2 used by R, STORE, BRANCH. rd used by R, I-ALU, LOAD, JAL, JALR, LUI, AUIPC.
- out_reg_write = rd used and rd != 0. out_is_jump covers JAL and JALR.
- Illegal cases, each raising out_illegal, string "ILLEGAL", all other flags 0, rd/rs 0:
  - unknown opcode;
  - R func7 not 0x00/0x20, or 0x20 with func3 not 0/5;
  - SLLI func7 != 0; SRLI/SRAI func7 not 0x00/0x20;
  - LOAD func3 3/6/7; STORE func3 > 2; BRANCH func3 2/3; JALR func3 != 0.
- Illegal instructions still produce out_valid so the trap is raised downstream.
- Load-use hazard = out_valid & out_is_load & out_rd != 0 & in_valid & (incoming used rs1 == out_rd or used rs2 == out_rd).
- in_ready = !reset & !flush & !hazard & (!out_valid | out_ready).
- Register update, priority order:
  - reset: out_valid 0, all fields 0, string "RESET".
  - flush: out_valid 0.
  - accept: load decode of in_instr, out_valid 1.
  - out_ready with no accept (including hazard): out_valid 0, which is the bubble.
  - otherwise hold.
- stall_load_use = hazard. It is combinational.

## Timing
- Latency 1 cycle: instruction accepted at edge N is on the outputs after edge N with out_valid=1.
- Throughput 1/cycle when out_ready is held high and there are no hazards.
- While out_valid & !out_ready, all out_* are stable and in_ready=0.
- Hazard inserts exactly one bubble cycle. In the following cycle out_valid=0, so the dependent instruction is accepted.
- flush and reset discard any in-flight instruction. A mid-stream reset returns every output to its reset value on the next edge, regardless of handshake state.
- in_ready and stall_load_use are combinational from current state and inputs; no combinational path from out_ready to out_valid.

## Test plan
- ADD x3,x1,x2 (0x002081B3), out_ready=1 -> next cycle out_valid=1, rd=3, rs1=1, rs2=2, alu=0, reg_write=1, string "ADD".
- SUB x5,x6,x7 (0x407302B3) then SRA variant with func7 0x40 -> alu=1, then out_illegal=1 (func7 0x40 invalid).
- LW x5,8(x1) (0x0080A283) then ADD x6,x5,x0 (0x00028333) back-to-back -> stall_load_use=1 for one cycle, one out_valid=0 bubble, ADD emitted on the following cycle.
- JAL x1,-4 (0xFFDFF0EF) -> imm=0xFFFFFFFC, rd=1, is_jump=1, alu=0, string "JAL"; instr 0x00000000 -> out_illegal=1, string "ILLEGAL".
- out_ready low 3 cycles with out_valid=1 -> outputs bit-stable, in_ready=0; raising out_ready drains the held instruction in 1 cycle.
- flush asserted with out_valid=1 -> out_valid=0 next cycle, in_ready=0 during flush; reset mid-stream -> out_valid=0, fields 0, string "RESET".
